// File: rtl/echo_pkt_framer.sv
// Frames the TCP RX session/data streams into packed {tx_meta, tlast, data} beats for the echo TX stage.
// Define ECHO_FRAMER_STATS_EN to add the stat_pkts / stat_segs counters.
module echo_pkt_framer #(
  parameter int MAX_SEG_BYTES = 4096,
  parameter int SESSION_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SESSION_W-1:0] s_axis_rx_meta_TDATA,
  input  logic                 s_axis_rx_meta_TVALID,
  output logic                 s_axis_rx_meta_TREADY,
  input  logic [511:0]         s_axis_rx_data_TDATA,
  input  logic [63:0]          s_axis_rx_data_TKEEP,
  input  logic                 s_axis_rx_data_TLAST,
  input  logic                 s_axis_rx_data_TVALID,
  output logic                 s_axis_rx_data_TREADY,
  output logic [544:0]         pkt_tx_TDATA,
  output logic                 pkt_tx_TVALID,
  input  logic                 pkt_tx_TREADY
`ifdef ECHO_FRAMER_STATS_EN
  ,
  output logic [31:0]          stat_pkts,
  output logic [31:0]          stat_segs
`endif
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state, state_nxt;
  logic [15:0]          acc, acc_nxt;
  logic [SESSION_W-1:0] session;
  logic [15:0]          session_ext;
  logic [6:0]           nbytes;
  logic [15:0]          sum;
  logic                 seg_end;
  logic                 meta_fire;
  logic                 data_fire;

  assign session_ext = 16'(session);
  assign meta_fire   = s_axis_rx_meta_TVALID && s_axis_rx_meta_TREADY;
  assign data_fire   = s_axis_rx_data_TVALID && s_axis_rx_data_TREADY;

  always_comb begin
    nbytes = '0;
    for (int b = 0; b < 64; b++) begin
      nbytes = nbytes + 7'(s_axis_rx_data_TKEEP[b]);
    end
  end

  assign sum     = acc + 16'(nbytes);
  assign seg_end = s_axis_rx_data_TLAST || (sum == 16'(MAX_SEG_BYTES));

  // Data is accepted whenever the single output slot is free or draining this cycle.
  always_comb begin
    state_nxt             = state;
    acc_nxt               = acc;
    s_axis_rx_meta_TREADY = 1'b0;
    s_axis_rx_data_TREADY = 1'b0;
    case (state)
      IDLE: begin
        s_axis_rx_meta_TREADY = !rst;
        if (meta_fire) begin
          state_nxt = STREAM;
          acc_nxt   = '0;
        end
      end
      STREAM: begin
        s_axis_rx_data_TREADY = !rst && (!pkt_tx_TVALID || pkt_tx_TREADY);
        if (data_fire) begin
          acc_nxt = seg_end ? 16'd0 : sum;
          if (s_axis_rx_data_TLAST) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      session <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      if (meta_fire) begin
        session <= s_axis_rx_meta_TDATA;
      end
    end
  end

  // Metadata rides only on the beat that closes a segment; other beats carry zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_tx_TVALID <= 1'b0;
      pkt_tx_TDATA  <= '0;
    end else if (data_fire) begin
      pkt_tx_TVALID <= 1'b1;
      pkt_tx_TDATA  <= {(seg_end ? {sum, session_ext} : 32'd0), seg_end, s_axis_rx_data_TDATA};
    end else if (pkt_tx_TREADY) begin
      pkt_tx_TVALID <= 1'b0;
    end
  end

`ifdef ECHO_FRAMER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pkts <= '0;
      stat_segs <= '0;
    end else begin
      if (data_fire && s_axis_rx_data_TLAST) begin
        stat_pkts <= stat_pkts + 32'd1;
      end
      if (pkt_tx_TVALID && pkt_tx_TREADY && pkt_tx_TDATA[512]) begin
        stat_segs <= stat_segs + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_echo_pkt_framer.sv
// Randomised self-checking bench for echo_pkt_framer: two instances (segment limits 4096 and 128)
// checked against a per-packet segmentation model kept in the bench.
module tb_echo_pkt_framer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0]  metaData  [2];
  logic         metaValid [2];
  logic         metaReady [2];
  logic [511:0] dataData  [2];
  logic [63:0]  dataKeep  [2];
  logic         dataLast  [2];
  logic         dataValid [2];
  logic         dataReady [2];
  logic [544:0] txData    [2];
  logic         txValid   [2];
  logic         txReady   [2];
  int           readyMode [2];
  int           maxSeg    [2] = '{4096, 128};
`ifdef ECHO_FRAMER_STATS_EN
  logic [31:0]  statPkts  [2];
  logic [31:0]  statSegs  [2];
`endif

  echo_pkt_framer dut0 (
    .clk(clk), .rst(rst),
    .s_axis_rx_meta_TDATA(metaData[0]), .s_axis_rx_meta_TVALID(metaValid[0]),
    .s_axis_rx_meta_TREADY(metaReady[0]),
    .s_axis_rx_data_TDATA(dataData[0]), .s_axis_rx_data_TKEEP(dataKeep[0]),
    .s_axis_rx_data_TLAST(dataLast[0]), .s_axis_rx_data_TVALID(dataValid[0]),
    .s_axis_rx_data_TREADY(dataReady[0]),
    .pkt_tx_TDATA(txData[0]), .pkt_tx_TVALID(txValid[0]), .pkt_tx_TREADY(txReady[0])
`ifdef ECHO_FRAMER_STATS_EN
    , .stat_pkts(statPkts[0]), .stat_segs(statSegs[0])
`endif
  );

  echo_pkt_framer #(.MAX_SEG_BYTES(128)) dut1 (
    .clk(clk), .rst(rst),
    .s_axis_rx_meta_TDATA(metaData[1]), .s_axis_rx_meta_TVALID(metaValid[1]),
    .s_axis_rx_meta_TREADY(metaReady[1]),
    .s_axis_rx_data_TDATA(dataData[1]), .s_axis_rx_data_TKEEP(dataKeep[1]),
    .s_axis_rx_data_TLAST(dataLast[1]), .s_axis_rx_data_TVALID(dataValid[1]),
    .s_axis_rx_data_TREADY(dataReady[1]),
    .pkt_tx_TDATA(txData[1]), .pkt_tx_TVALID(txValid[1]), .pkt_tx_TREADY(txReady[1])
`ifdef ECHO_FRAMER_STATS_EN
    , .stat_pkts(statPkts[1]), .stat_segs(statSegs[1])
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string tag, input logic [544:0] got, input logic [544:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Expected beats and acceptance cycles, one queue pair per instance.
  logic [544:0] exp0[$], exp1[$];
  int           lat0[$], lat1[$];
  int           modelPkts[2] = '{0, 0};
  int           modelSegs[2] = '{0, 0};
  int           segsSeen[2]  = '{0, 0};
  logic [31:0]  lastMeta[2];
  bit           prevStall[2] = '{0, 0};
  logic [544:0] prevData[2];

  function automatic int expSize(input int i);
    return (i == 0) ? exp0.size() : exp1.size();
  endfunction

  function automatic logic [544:0] expPop(input int i);
    return (i == 0) ? exp0.pop_front() : exp1.pop_front();
  endfunction

  function automatic int latSize(input int i);
    return (i == 0) ? lat0.size() : lat1.size();
  endfunction

  function automatic int latPop(input int i);
    return (i == 0) ? lat0.pop_front() : lat1.pop_front();
  endfunction

  function automatic logic [511:0] randData();
    logic [511:0] r;
    for (int w = 0; w < 16; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] keepOf(input int n);
    logic [63:0] k;
    k = '0;
    for (int b = 0; b < n; b++) k[b] = 1'b1;
    return k;
  endfunction

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      case (readyMode[g])
        1:       txReady[g] = ~txReady[g];
        2:       txReady[g] = 1'($urandom_range(0, 1));
        default: txReady[g] = 1'b1;
      endcase
    end
  end

  task automatic monitorOne(input int g);
    if (rst) begin
      prevStall[g] = 0;
      return;
    end
    if (txValid[g]) begin
      if (prevStall[g]) checkOutput("hold_stable", txData[g], prevData[g]);
      else if (latSize(g) == 0) checkOutput("extra_beat", 1, 0);
      else checkOutput("latency", cyc, latPop(g));
      if (txReady[g]) begin
        if (expSize(g) == 0) checkOutput("beat_unexpected", 1, 0);
        else checkOutput("beat", txData[g], expPop(g));
        if (txData[g][512]) begin
          segsSeen[g]++;
          lastMeta[g] = txData[g][544:513];
        end
      end
      prevStall[g] = !txReady[g];
      prevData[g]  = txData[g];
    end else begin
      if (prevStall[g]) checkOutput("valid_dropped", 0, 1);
      prevStall[g] = 0;
    end
  endtask

  always begin
    @(negedge clk);
    #2;
    for (int g = 0; g < 2; g++) monitorOne(g);
  end

  // Sends one RX packet on instance i and records what the framer must emit.
  task automatic applyStimulus(input int i, input logic [15:0] sess, input int nbeats,
                               input logic [63:0] lastKeep, input bit earlyNext,
                               input logic [15:0] nextSess, input int abortAfter);
    int acc;
    int n;
    bit seg;
    logic [31:0] meta;
    acc = 0;
    metaData[i]  = sess;
    metaValid[i] = 1'b1;
    dataData[i]  = randData();
    dataKeep[i]  = (nbeats == 1) ? lastKeep : '1;
    dataLast[i]  = (nbeats == 1);
    dataValid[i] = 1'b1;
    #1;
    checkOutput("data_held_idle", dataReady[i], 0);
    n = 0;
    while (!metaReady[i] && n < 300) begin
      @(negedge clk); #1; n++;
    end
    if (!metaReady[i]) begin
      checkOutput("meta_timeout", 0, 1);
      metaValid[i] = 1'b0;
      dataValid[i] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    metaValid[i] = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (b > 0) begin
        dataData[i] = randData();
        dataKeep[i] = (b == nbeats - 1) ? lastKeep : '1;
        dataLast[i] = (b == nbeats - 1);
      end
      if (earlyNext && b == 1) begin
        metaData[i]  = nextSess;
        metaValid[i] = 1'b1;
      end
      #1;
      n = 0;
      while (!dataReady[i] && n < 300) begin
        if (earlyNext && b >= 1) checkOutput("meta_blocked", metaReady[i], 0);
        @(negedge clk); #1; n++;
      end
      if (!dataReady[i]) begin
        checkOutput("data_timeout", 0, 1);
        dataValid[i] = 1'b0;
        return;
      end
      if (earlyNext && b >= 1) checkOutput("meta_blocked", metaReady[i], 0);
      @(posedge clk);
      @(negedge clk);
      acc  = acc + $countones(dataKeep[i]);
      seg  = dataLast[i] || (acc == maxSeg[i]);
      meta = seg ? {acc[15:0], sess} : 32'h0;
      if (i == 0) begin
        exp0.push_back({meta, seg, dataData[i]});
        lat0.push_back(cyc);
      end else begin
        exp1.push_back({meta, seg, dataData[i]});
        lat1.push_back(cyc);
      end
      if (seg) begin
        modelSegs[i]++;
        acc = 0;
      end
      if (dataLast[i]) modelPkts[i]++;
      if (abortAfter > 0 && b + 1 == abortAfter) begin
        dataValid[i] = 1'b0;
        return;
      end
    end
    dataValid[i] = 1'b0;
    dataLast[i]  = 1'b0;
    if (earlyNext) checkOutput("meta_after_tlast", metaReady[i], 1);
  endtask

  task automatic drainOutput(input int i);
    int n;
    n = 0;
    while ((expSize(i) != 0 || txValid[i]) && n < 500) begin
      @(negedge clk); n++;
    end
    checkOutput("drain", expSize(i), 0);
`ifdef ECHO_FRAMER_STATS_EN
    checkOutput("stat_pkts", statPkts[i], modelPkts[i]);
    checkOutput("stat_segs", statSegs[i], modelSegs[i]);
`endif
  endtask

  initial begin
    int s0;
    int nb;
    int inst;
    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      metaData[g] = '0; metaValid[g] = 1'b0;
      dataData[g] = '0; dataKeep[g] = '0; dataLast[g] = 1'b0; dataValid[g] = 1'b0;
      txReady[g] = 1'b1; readyMode[g] = 0;
    end
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_tvalid", txValid[0], 0);
    checkOutput("rst_tdata", txData[0], 0);
    checkOutput("rst_meta_ready", metaReady[0], 0);
    checkOutput("rst_data_ready", dataReady[0], 0);
    repeat (3) @(negedge clk);
    #3 rst = 1'b0;
    @(negedge clk); #1;
    checkOutput("idle_meta_ready", metaReady[0], 1);
    checkOutput("idle_data_ready", dataReady[0], 0);
    @(negedge clk);

    applyStimulus(0, 16'h0005, 3, '1, 0, 0, 0);
    drainOutput(0);
    checkOutput("three_full_meta", lastMeta[0], 32'h00C00005);

    applyStimulus(0, 16'h0012, 1, 64'hFFFF, 0, 0, 0);
    drainOutput(0);
    checkOutput("short_meta", lastMeta[0], 32'h00100012);

    s0 = segsSeen[1];
    applyStimulus(1, 16'h0007, 5, '1, 0, 0, 0);
    drainOutput(1);
    checkOutput("seg128_count", segsSeen[1] - s0, 3);
    checkOutput("seg128_meta", lastMeta[1], 32'h00400007);

    readyMode[0] = 1;
    applyStimulus(0, 16'h0021, 4, '1, 0, 0, 0);
    drainOutput(0);
    checkOutput("toggle_meta", lastMeta[0], 32'h01000021);
    readyMode[0] = 0;

    applyStimulus(0, 16'h00A0, 4, '1, 1, 16'h00B0, 0);
    applyStimulus(0, 16'h00B0, 2, '1, 0, 0, 0);
    drainOutput(0);
    checkOutput("b_after_a_meta", lastMeta[0], 32'h008000B0);

    applyStimulus(0, 16'h0033, 3, 64'h0, 0, 0, 0);
    drainOutput(0);
    checkOutput("empty_last_meta", lastMeta[0], 32'h00800033);

    applyStimulus(0, 16'h0044, 1, 64'h0, 0, 0, 0);
    drainOutput(0);
    checkOutput("zero_len_meta", lastMeta[0], 32'h00000044);

    s0 = segsSeen[1];
    applyStimulus(1, 16'h0009, 2, '1, 0, 0, 0);
    drainOutput(1);
    checkOutput("tlast_at_max_count", segsSeen[1] - s0, 1);
    checkOutput("tlast_at_max_meta", lastMeta[1], 32'h00800009);

    applyStimulus(0, 16'h0055, 4, '1, 0, 0, 2);
    #3 rst = 1'b1;
    #1;
    checkOutput("midrst_tvalid", txValid[0], 0);
    checkOutput("midrst_meta_ready", metaReady[0], 0);
    exp0.delete();
    lat0.delete();
    modelPkts[0] = 0;
    modelSegs[0] = 0;
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    exp1.delete();
    lat1.delete();
    modelPkts[1] = 0;
    modelSegs[1] = 0;
    @(negedge clk); #1;
    checkOutput("after_rst_idle", metaReady[0], 1);
    @(negedge clk);
    applyStimulus(0, 16'h0056, 2, '1, 0, 0, 0);
    drainOutput(0);
    checkOutput("after_rst_meta", lastMeta[0], 32'h00800056);

    for (int it = 0; it < 24; it++) begin
      inst = (it == 0) ? 0 : int'($urandom_range(0, 1));
      nb   = (it == 0) ? 66 : int'($urandom_range(1, 8));
      readyMode[inst] = 2;
      applyStimulus(inst, 16'($urandom), nb, keepOf(int'($urandom_range(0, 64))), 0, 0, 0);
      drainOutput(inst);
      readyMode[inst] = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule
